// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Lets two requesters share one single-port synchronous BRAM that has a
//   1-cycle registered read. Accesses are arbitrated round-robin one at a
//   time. A requester can lock the port so that a read-modify-write sequence
//   is atomic. A watchdog counter limits how long a lock can be held, so the
//   other requester cannot starve.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   rN_req/we/addr/wdata      request, write enable, word address, write data
//   rN_lock                   request or hold exclusive ownership
//   rN_gnt                    access accepted this cycle (combinational)
//   rN_rvalid/rdata           read data for requester N, one cycle after its read
//   mem_addr/din/we           BRAM port driven by the current winner (zero when idle)
//   mem_dout                  BRAM registered read data
module bram_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r0_lock,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_lock,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] LCNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state_r;
    logic             last_win_r;   // 1 = r1 won last, so r0 wins the next tie
    logic [CNT_W-1:0] lcnt_r;
    logic             r0_rvalid_r;
    logic             r1_rvalid_r;
    logic             gnt0_s;
    logic             gnt1_s;

    // Grant decision: a lock owner gets exclusive access, otherwise round-robin.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (r0_req && r1_req) begin
                        gnt0_s = last_win_r;
                        gnt1_s = ~last_win_r;
                    end else begin
                        gnt0_s = r0_req;
                        gnt1_s = r1_req;
                    end
                end
                LOCK0: begin
                    gnt0_s = r0_req;
                    gnt1_s = 1'b0;
                end
                LOCK1: begin
                    gnt0_s = 1'b0;
                    gnt1_s = r1_req;
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Memory port mux: winner's command, all zeros when nobody is granted.
    always_comb begin
        mem_addr = {ADDR_W{1'b0}};
        mem_din  = {DATA_W{1'b0}};
        mem_we   = 1'b0;
        if (gnt0_s) begin
            mem_addr = r0_addr;
            mem_din  = r0_wdata;
            mem_we   = r0_we;
        end else if (gnt1_s) begin
            mem_addr = r1_addr;
            mem_din  = r1_wdata;
            mem_we   = r1_we;
        end else begin
            mem_addr = {ADDR_W{1'b0}};
            mem_din  = {DATA_W{1'b0}};
            mem_we   = 1'b0;
        end
    end

    // Arbitration state, lock watchdog and read-return tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            last_win_r  <= 1'b1;
            lcnt_r      <= {CNT_W{1'b0}};
            r0_rvalid_r <= 1'b0;
            r1_rvalid_r <= 1'b0;
        end else begin
            // gnt already implies req, so only the write flag matters here
            r0_rvalid_r <= gnt0_s & ~r0_we;
            r1_rvalid_r <= gnt1_s & ~r1_we;
            if (gnt0_s) begin
                last_win_r <= 1'b0;
            end else if (gnt1_s) begin
                last_win_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    lcnt_r <= {CNT_W{1'b0}};
                    if (gnt0_s && r0_lock) begin
                        state_r <= LOCK0;
                    end else if (gnt1_s && r1_lock) begin
                        state_r <= LOCK1;
                    end
                end
                LOCK0: begin
                    if (!r0_lock || (lcnt_r == LCNT_LAST)) begin
                        state_r    <= IDLE;
                        lcnt_r     <= {CNT_W{1'b0}};
                        // owner keeps last_win so a waiting r1 wins the next tie
                        last_win_r <= 1'b0;
                    end else begin
                        lcnt_r <= lcnt_r + CNT_W'(1);
                    end
                end
                LOCK1: begin
                    if (!r1_lock || (lcnt_r == LCNT_LAST)) begin
                        state_r    <= IDLE;
                        lcnt_r     <= {CNT_W{1'b0}};
                        last_win_r <= 1'b1;
                    end else begin
                        lcnt_r <= lcnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    lcnt_r  <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign r0_gnt    = gnt0_s;
    assign r1_gnt    = gnt1_s;
    assign r0_rvalid = r0_rvalid_r;
    assign r1_rvalid = r1_rvalid_r;
    assign r0_rdata  = mem_dout;
    assign r1_rdata  = mem_dout;

endmodule
